// File: rtl/teclado_port_responder.sv
// rtl/teclado_port_responder.sv - keyboard scan-code FIFO with port-mapped read/control and interrupt handshake
// Sits between the keyboard decoder and the processor I/O block.
module teclado_port_responder #(
  parameter logic [7:0] PORT_DATA    = 8'h31,
  parameter logic [7:0] PORT_CTRL    = 8'h30,
  parameter int         DEPTH        = 4,
  parameter int         REARM_CYCLES = 10
) (
  input  logic                     reloj,
  input  logic                     reset,
  input  logic                     tecla_strobe,
  input  logic [7:0]               tecla_codigo,
  input  logic [7:0]               port_id,
  input  logic                     read_strobe,
  input  logic                     write_strobe,
  input  logic [7:0]               out_port,
  input  logic                     interrupt_ack,
  output logic [7:0]               dato_tec,
  output logic                     interrupt_teclado,
  output logic [$clog2(DEPTH):0]   nivel,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = (REARM_CYCLES > 1) ? $clog2(REARM_CYCLES) : 1;
  localparam logic [LW-1:0] FULL_LVL   = LW'(DEPTH);
  localparam logic [CW-1:0] REARM_LOAD = CW'(REARM_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK, HOLDOFF} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [7:0]      mem [DEPTH];
  logic            enable;
  logic            ctrl_wr, flush, pop, push, drop;

  assign ctrl_wr = write_strobe && (port_id == PORT_CTRL);
  assign flush   = ctrl_wr && out_port[2];
  assign pop     = read_strobe && (port_id == PORT_DATA) && (nivel != '0);
  // A full FIFO still takes a push when the same cycle frees a slot.
  assign push    = tecla_strobe && ((nivel < FULL_LVL) || pop);
  // A flush discards the incoming code silently rather than counting it as lost.
  assign drop    = tecla_strobe && !push && !flush;

  always_ff @(posedge reloj) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      nivel    <= '0;
      overflow <= 1'b0;
      enable   <= 1'b1;
    end else begin
      if (ctrl_wr)
        enable <= out_port[0];
      if (drop)
        overflow <= 1'b1;
      else if (ctrl_wr && out_port[1])
        overflow <= 1'b0;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        nivel  <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + PW'(1);
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)
          nivel <= nivel + LW'(1);
        else if (pop && !push)
          nivel <= nivel - LW'(1);
      end
    end
  end

  always_ff @(posedge reloj) begin
    if (!reset && push && !flush)
      mem[wr_ptr] <= tecla_codigo;
  end

  assign dato_tec = (nivel != '0) ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge reloj) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (enable && (nivel != '0))
          state_next = REQ;
      end
      REQ: begin
        state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        // Disabling does not cancel an outstanding request; only ack or drain do.
        if (interrupt_ack) begin
          state_next = HOLDOFF;
          cnt_next   = REARM_LOAD;
        end else if (nivel == '0) begin
          state_next = IDLE;
        end
      end
      HOLDOFF: begin
        if (cnt == '0)
          state_next = IDLE;
        else
          cnt_next = cnt - CW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  assign interrupt_teclado = (state == REQ);

endmodule

// File: doc/teclado_port_responder.md
# teclado_port_responder

Peripheral-side responder for the processor port interface: buffers keyboard scan codes, raises the one-cycle keyboard interrupt request, and presents the head code on `dato_tec` for the processor's port read. It drains one entry per processor read of the data port and takes control writes from the processor's output port. It sits between the keyboard decoder and the I/O interface block, feeding that block's `interrupt_teclado` and `dato_tec` inputs.

## Interface
- `PORT_DATA`, 8'h31: port_id value of the data port; a read of this port pops the FIFO.
- `PORT_CTRL`, 8'h30: port_id value of the control port; a write to this port updates control.
- `DEPTH`, 4: FIFO depth; power of two, 2..16.
- `REARM_CYCLES`, 10: hold-off length, in clocks, after an acknowledge before a new request may issue; at least 1.

- `reloj` in 1: clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `tecla_strobe` in 1: one-cycle pulse; `tecla_codigo` is valid in that cycle.
- `tecla_codigo` in 8: scan code from the keyboard decoder.
- `port_id` in 8: processor port address.
- `read_strobe` in 1: processor input-port read cycle.
- `write_strobe` in 1: processor output-port write cycle.
- `out_port` in 8: processor write data. Bit 0 is interrupt enable, bit 1 clears overflow, bit 2 flushes the FIFO.
- `interrupt_ack` in 1: processor interrupt acknowledge.
- `dato_tec` out 8: FIFO head, or 8'h00 when the FIFO is empty.
- `interrupt_teclado` out 1: one-cycle interrupt request pulse.
- `nivel` out $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.
- `overflow` out 1: sticky flag, set when a code is dropped because the FIFO is full.

## Operation
- **Reset values:**
  - `nivel`, read and write pointers: 0.
  - `overflow`: 0.
  - Interrupt enable: 1.
  - FSM: IDLE.
  - `interrupt_teclado`: 0.
  - `dato_tec`: 8'h00.
- **Push condition:** `tecla_strobe` and (`nivel` < DEPTH, or a pop in the same cycle).
  - A rejected push leaves the FIFO unchanged and sets `overflow`.
- **Pop condition:** `read_strobe` and `port_id`==PORT_DATA and `nivel` > 0.
  - A pop on an empty FIFO does nothing and is not an error.
- **Simultaneous push and pop:** both take effect and `nivel` is unchanged. A full FIFO therefore accepts the push with no overflow.
- **Control write:** `write_strobe` and `port_id`==PORT_CTRL.
  - Bit 0 is loaded into enable.
  - Bit 1 = 1 clears `overflow`. If a dropped push occurs in the same cycle, the set wins.
  - Bit 2 = 1 sets pointers and `nivel` to 0. Flush beats a same-cycle push and pop; the push is discarded without setting `overflow`.
- **Pointers:** width $clog2(DEPTH). They wrap modulo DEPTH with no special case.
- **Interrupt FSM** (Moore; `interrupt_teclado` = state==REQ):
  - IDLE: enable and `nivel` > 0 → REQ.
  - REQ: unconditional → WAIT_ACK (output pulse is exactly one cycle).
  - WAIT_ACK: `interrupt_ack` → HOLDOFF and load the hold-off counter with REARM_CYCLES-1. Otherwise, `nivel`==0 → IDLE. Clearing enable does not leave this state.
  - HOLDOFF: counter decrements each cycle; at 0 → IDLE. `interrupt_ack` here is ignored.
- **Re-request:** if codes remain after HOLDOFF and enable is 1, a new request follows IDLE→REQ. There is at most one request per acknowledge or drain.
- **Reset mid-operation:** returns every register to its reset value on the next edge, regardless of state or stored codes.

## Timing
- A push at edge k makes `nivel` = 1 and `dato_tec` valid after edge k. The FSM enters REQ at edge k+1, so `interrupt_teclado` is high for the cycle after k+1 only.
- `dato_tec` is driven from registered head data. It is stable throughout the read cycle, so the processor samples it in the same cycle as `read_strobe`. After the pop edge it shows the next entry, or 8'h00.
- An ack sampled at edge a gives HOLDOFF during a+1..a+REARM_CYCLES, then IDLE. The earliest next `interrupt_teclado` is in the cycle after edge a+REARM_CYCLES+1.
- `overflow` and `nivel` update on the same edge as the causing event.

## Test plan
- **Reset, push, read:** reset, then push 8'h1C.
  - `interrupt_teclado` is high for exactly one cycle, 2 cycles after the strobe.
  - `dato_tec`=8'h1C.
  - A read of 8'h31 gives `nivel`=0 and `dato_tec`=8'h00.
- **Fill and overflow:** push 8'h01..8'h05 with DEPTH=4.
  - `nivel`=4 and `overflow`=1.
  - Reads return 01, 02, 03, 04.
  - Write 8'h03 to 8'h30 → `overflow`=0.
- **Full FIFO, simultaneous push and pop:** with 4 codes stored, push 8'hAA while reading 8'h31.
  - `nivel` stays 4 and `overflow`=0.
  - The last read returns 8'hAA.
- **Ack hold-off:** with 2 codes queued, ack the request.
  - No request during the 10 hold-off cycles.
  - A second pulse follows once hold-off ends.
  - A drain in WAIT_ACK without ack → IDLE, with no further pulse.
- **Control:** write 8'h00 (disable), then push. No interrupt fires.
  - Write 8'h05 (enable + flush) together with a same-cycle push: `nivel`=0, `overflow` unchanged, no request.
- **Reset mid-operation:** assert `reset` in WAIT_ACK with 3 codes queued. Next cycle: `nivel`=0, `dato_tec`=8'h00, FSM IDLE, no pulse.
